// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the sequencer state encoding, LCD_CTRL command codes and default sizing.
package lcd_seq_pkg;

    localparam int CMD_W       = 4;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_TIMEOUT = 256;

    localparam logic [CMD_W-1:0] CMD_WRITE      = 4'h0;
    localparam logic [CMD_W-1:0] CMD_SHIFT_UP   = 4'h1;
    localparam logic [CMD_W-1:0] CMD_SHIFT_DOWN = 4'h2;
    localparam logic [CMD_W-1:0] CMD_SHIFT_LEFT = 4'h3;
    localparam logic [CMD_W-1:0] CMD_SHIFT_RGT  = 4'h4;
    localparam logic [CMD_W-1:0] CMD_MAX        = 4'h5;
    localparam logic [CMD_W-1:0] CMD_MIN        = 4'h6;
    localparam logic [CMD_W-1:0] CMD_AVERAGE    = 4'h7;
    localparam logic [CMD_W-1:0] CMD_ROT_CCW    = 4'h8;
    localparam logic [CMD_W-1:0] CMD_ROT_CW     = 4'h9;
    localparam logic [CMD_W-1:0] CMD_MIRROR_X   = 4'hA;
    localparam logic [CMD_W-1:0] CMD_MIRROR_Y   = 4'hB;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ISSUE    = 3'd2,
        HOLD     = 3'd3,
        FIN      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO, DEPTH x CMD_W, with push/pop/flush and an occupancy count.
// Latency: a pushed entry reaches the head the cycle after its push edge; head is read combinationally.
// Backpressure: push dropped while full, pop ignored while empty, flush overrides both.
module lcd_cmd_fifo
    import lcd_seq_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [CMD_W-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CMD_W-1:0] o_head_dat,
    output logic             o_full,
    output logic [ADDR_W:0]  o_count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [CMD_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_cnt;
    logic              w_push;
    logic              w_pop;

    assign o_full     = (r_cnt == FULL_CNT);
    assign o_count    = r_cnt;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full && !i_flush;
    assign w_pop      = i_pop && (r_cnt != '0) && !i_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (ADDR_W + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (ADDR_W + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD_CTRL command initiator; optional busy watchdog enabled by LCDSEQ_TIMEOUT_EN.
// Latency: start sampled at edge N (busy=0, queue non-empty) -> cmd_valid after edge N+2; issues >=3 cycles apart.
// Backpressure: push_ready low when the queue is full; issue stalls while LCD_CTRL reports busy.
module lcd_cmd_seq
    import lcd_seq_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] push_cmd,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             start,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    input  logic             busy,
    input  logic             done,
    output logic [7:0]       issued_cnt,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             lcd_done,
    output logic             err
);

    localparam int ADDR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("lcd_cmd_seq: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CMD_W-1:0] r_cmd;
    logic             r_cmd_valid;
    logic [7:0]       r_issued_cnt;
    logic             r_seq_busy;
    logic             r_seq_done;
    logic             r_lcd_done;
    logic             w_pop;
    logic             w_timeout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [ADDR_W:0]  w_fifo_cnt;
    logic [CMD_W-1:0] w_head_dat;

    lcd_cmd_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (push_valid),
        .i_push_dat (push_cmd),
        .i_pop      (w_pop),
        .i_flush    (w_timeout),
        .o_head_dat (w_head_dat),
        .o_full     (w_fifo_full),
        .o_count    (w_fifo_cnt)
    );

    assign w_fifo_empty = (w_fifo_cnt == '0);
    assign push_ready   = !w_fifo_full;

`ifdef LCDSEQ_TIMEOUT_EN
    localparam int                WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    // Fires on the TIMEOUT-th consecutive cycle spent waiting on busy.
    assign w_timeout = (r_state == WAIT_RDY) && busy && (r_wd_cnt == WD_LAST);
    assign err       = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == WAIT_RDY) && busy && !w_timeout) r_wd_cnt <= r_wd_cnt + WD_W'(1);
            else                                             r_wd_cnt <= '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE:     if (start) w_state_nxt = WAIT_RDY;
            WAIT_RDY: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else if (!busy) begin
                    if (!w_fifo_empty) begin
                        w_state_nxt = ISSUE;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = FIN;
                    end
                end
            end
            ISSUE:    w_state_nxt = HOLD;
            HOLD:     w_state_nxt = WAIT_RDY;
            FIN:      w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cmd        <= '0;
            r_cmd_valid  <= 1'b0;
            r_issued_cnt <= '0;
            r_seq_busy   <= 1'b0;
            r_seq_done   <= 1'b0;
            r_lcd_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= (r_state == ISSUE);
            r_seq_done  <= (r_state == FIN);
            r_seq_busy  <= (w_state_nxt != IDLE);
            if (w_pop) r_cmd <= w_head_dat;
            if ((r_state == IDLE) && start) begin
                r_issued_cnt <= '0;
                r_lcd_done   <= 1'b0;
            end else begin
                if (r_state == ISSUE)     r_issued_cnt <= r_issued_cnt + 8'd1;
                if (done && r_seq_busy)   r_lcd_done   <= 1'b1;
            end
        end
    end

    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign issued_cnt = r_issued_cnt;
    assign seq_busy   = r_seq_busy;
    assign seq_done   = r_seq_done;
    assign lcd_done   = r_lcd_done;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: ordering, full queue, empty run, busy responder, mid-run reset, watchdog.
module tb_lcd_cmd_seq;
    import lcd_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] push_cmd;
    logic       push_valid;
    logic       push_ready;
    logic       start;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy_force;
    logic       resp_busy;
    logic       resp_done;
    wire        busy_w = busy_force | resp_busy;
    logic [7:0] issued_cnt;
    logic       seq_busy;
    logic       seq_done;
    logic       lcd_done;
    logic       err;

    lcd_cmd_seq dut (
        .clk        (clk),
        .reset      (reset),
        .push_cmd   (push_cmd),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .start      (start),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy_w),
        .done       (resp_done),
        .issued_cnt (issued_cnt),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .lcd_done   (lcd_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntot = 0;
    int nbad = 0;
    int cyc  = 0;
    int n_done = 0;
    int viol = 0;
    logic [3:0] q_cmd[$];
    int         q_t[$];

    logic [3:0] cmd_tab [12] = '{CMD_WRITE, CMD_SHIFT_UP, CMD_SHIFT_DOWN, CMD_SHIFT_LEFT,
                                 CMD_SHIFT_RGT, CMD_MAX, CMD_MIN, CMD_AVERAGE,
                                 CMD_ROT_CCW, CMD_ROT_CW, CMD_MIRROR_X, CMD_MIRROR_Y};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid) begin
            q_cmd.push_back(cmd);
            q_t.push_back(cyc);
            if (busy_w) viol <= viol + 1;
        end
        if (seq_done) n_done <= n_done + 1;
    end

    // LCD_CTRL stand-in: busy for 3 cycles after each issue, done pulse after a WRITE.
    logic       resp_en;
    int         resp_left;
    logic [3:0] resp_cmd;
    always @(posedge clk) begin
        if (!resp_en) begin
            resp_left <= 0;
            resp_busy <= 1'b0;
            resp_done <= 1'b0;
        end else if (cmd_valid) begin
            resp_left <= 3;
            resp_busy <= 1'b1;
            resp_cmd  <= cmd;
            resp_done <= 1'b0;
        end else if (resp_left > 1) begin
            resp_left <= resp_left - 1;
            resp_done <= 1'b0;
        end else begin
            resp_done <= (resp_left == 1) && (resp_cmd == CMD_WRITE);
            resp_left <= 0;
            resp_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c);
        push_cmd   = c;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic start_seq(output int s);
        q_cmd.delete();
        q_t.delete();
        s     = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int  n0   = n_done;
        logic seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (n_done != n0) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    int s;
    int n0;
    int bad_ord;
    int exp_n;
    logic exp_err;

    initial begin
        reset      = 1'b0;
        push_cmd   = '0;
        push_valid = 1'b0;
        start      = 1'b0;
        busy_force = 1'b0;
        resp_en    = 1'b0;
        resp_cmd   = '0;
        repeat (2) tick();
        chk("rst_push_ready", 32'(push_ready), 1);
        chk("rst_cmd_valid",  32'(cmd_valid), 0);
        chk("rst_cmd",        32'(cmd), 0);
        chk("rst_issued",     32'(issued_cnt), 0);
        chk("rst_seq_busy",   32'(seq_busy), 0);
        chk("rst_seq_done",   32'(seq_done), 0);
        chk("rst_lcd_done",   32'(lcd_done), 0);
        chk("rst_err",        32'(err), 0);
        reset = 1'b1;
        tick();

        // 1: three commands issued in order after busy drops
        push(CMD_SHIFT_UP); push(CMD_SHIFT_DOWN); push(CMD_WRITE);
        busy_force = 1'b1;
        repeat (5) tick();
        busy_force = 1'b0;
        n0 = n_done;
        start_seq(s);
        wait_done("t1_done", 40);
        repeat (3) tick();
        chk("t1_n_issued", q_cmd.size(), 3);
        if (q_cmd.size() == 3) begin
            chk("t1_cmd0", 32'(q_cmd[0]), 1);
            chk("t1_cmd1", 32'(q_cmd[1]), 2);
            chk("t1_cmd2", 32'(q_cmd[2]), 0);
            chk("t1_latency", 32'(q_t[0] - s), 3);
            chk("t1_gap", 32'(q_t[1] - q_t[0]), 3);
        end
        chk("t1_issued_cnt", 32'(issued_cnt), 3);
        chk("t1_one_done", 32'(n_done - n0), 1);
        chk("t1_seq_busy", 32'(seq_busy), 0);

        // 2: 65 pushes into a 64-deep queue
        for (int i = 0; i < 64; i++) push(cmd_tab[i % 12]);
        chk("t2_full", 32'(push_ready), 0);
        push(CMD_MIRROR_Y);
        start_seq(s);
        wait_done("t2_done", 400);
        chk("t2_n_issued", q_cmd.size(), 64);
        bad_ord = 0;
        for (int i = 0; i < 64 && i < q_cmd.size(); i++)
            if (q_cmd[i] !== cmd_tab[i % 12]) bad_ord++;
        chk("t2_order", 32'(bad_ord), 0);
        chk("t2_issued_cnt", 32'(issued_cnt), 64);
        chk("t2_ready_again", 32'(push_ready), 1);

        // 4: responder holds busy after each issue
        resp_en = 1'b1;
        push(CMD_SHIFT_LEFT); push(CMD_WRITE); push(CMD_ROT_CW);
        start_seq(s);
        wait_done("t4_done", 100);
        chk("t4_n_issued", q_cmd.size(), 3);
        if (q_cmd.size() == 3) begin
            chk("t4_cmd1", 32'(q_cmd[1]), 0);
            chk("t4_gap01", 32'(q_t[1] - q_t[0]), 6);
            chk("t4_gap12", 32'(q_t[2] - q_t[1]), 6);
        end
        chk("t4_no_vld_busy", 32'(viol), 0);
        chk("t4_lcd_done", 32'(lcd_done), 1);
        resp_en = 1'b0;
        repeat (2) tick();

        // 3: empty queue start
        start_seq(s);
        wait_done("t3_done", 10);
        chk("t3_no_cmd", q_cmd.size(), 0);
        chk("t3_done_lat", 32'(cyc - s), 4);
        chk("t3_lcd_done_clr", 32'(lcd_done), 0);
        chk("t3_issued_clr", 32'(issued_cnt), 0);

        // 6: busy stuck high
        push(CMD_MAX); push(CMD_MIN); push(CMD_AVERAGE);
        busy_force = 1'b1;
        n0 = n_done;
        start_seq(s);
        while (cyc < s + 256) tick();
        chk("t6_err_before", 32'(err), 0);
        chk("t6_busy_before", 32'(seq_busy), 1);
        tick();
`ifdef LCDSEQ_TIMEOUT_EN
        exp_err = 1'b1;
        exp_n   = 0;
`else
        exp_err = 1'b0;
        exp_n   = 3;
`endif
        chk("t6_err", 32'(err), 32'(exp_err));
        chk("t6_seq_busy", 32'(seq_busy), 32'(!exp_err));
        chk("t6_no_done", 32'(n_done - n0), 0);
        chk("t6_no_cmd", q_cmd.size(), 0);
        busy_force = 1'b0;
        start_seq(s);
        wait_done("t6_drain_done", 40);
        chk("t6_drain_n", q_cmd.size(), 32'(exp_n));
        chk("t6_err_sticky", 32'(err), 32'(exp_err));

        // 5: reset mid-run
        push(CMD_MAX); push(CMD_MIN); push(CMD_AVERAGE); push(CMD_ROT_CCW); push(CMD_MIRROR_X);
        start_seq(s);
        for (int i = 0; i < 30 && q_cmd.size() < 2; i++) tick();
        chk("t5_two_issued", q_cmd.size(), 2);
        reset = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(cmd_valid), 0);
        chk("t5_rst_cmd", 32'(cmd), 0);
        chk("t5_rst_issued", 32'(issued_cnt), 0);
        chk("t5_rst_seq_busy", 32'(seq_busy), 0);
        chk("t5_rst_ready", 32'(push_ready), 1);
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("t5_no_more_cmd", q_cmd.size(), 2);
        start_seq(s);
        wait_done("t5_empty_done", 10);
        chk("t5_fifo_flushed", q_cmd.size(), 0);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
